// File: rtl/packet_merger.sv
// packet_merger: 2-to-1 packet-atomic AXI-Stream merger with a registered output stage.
// Define PACKET_MERGER_STARVE_GUARD_EN to bound how long the low-priority path can starve.
module packet_merger #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis0_tdata,
  input  logic                    s_axis0_tvalid,
  input  logic                    s_axis0_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis0_tkeep,
  output logic                    s_axis0_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis1_tdata,
  input  logic                    s_axis1_tvalid,
  input  logic                    s_axis1_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis1_tkeep,
  output logic                    s_axis1_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  input  logic [1:0]              merge_mode
);
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [1:0] IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2;
  logic [1:0] state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KW-1:0] tkeep_q;
  logic tlast_q, tuser_q, tvalid_q;
  logic can_load, both_v, locked, prio_mode, prio_path, tie_grant, grant, sel;
  logic active, in_valid, in_last, accept, arb;
  assign can_load  = !tvalid_q || m_axis_tready;
  assign both_v    = s_axis0_tvalid && s_axis1_tvalid;
  assign locked    = (state_q == LOCK0) || (state_q == LOCK1);
  assign prio_mode = (merge_mode == 2'b01) || (merge_mode == 2'b10);
  assign prio_path = merge_mode == 2'b01;
`ifdef PACKET_MERGER_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_q, starve_d;
  logic other_valid;
  assign other_valid = prio_path ? s_axis0_tvalid : s_axis1_tvalid;
  // A full counter hands the next tie to the waiting path, which also clears it.
  assign tie_grant = prio_mode ? ((starve_q == LIMIT) ? !prio_path : prio_path) : !last_grant_q;
  assign starve_d  = !arb ? starve_q :
                     (prio_mode && sel == prio_path && other_valid) ?
                     ((starve_q == LIMIT) ? starve_q : starve_q + 1'b1) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else starve_q <= starve_d;
  end
`else
  assign tie_grant = prio_mode ? prio_path : !last_grant_q;
`endif
  assign grant    = both_v ? tie_grant : s_axis1_tvalid;
  assign sel      = (state_q == LOCK0) ? 1'b0 : (state_q == LOCK1) ? 1'b1 : grant;
  assign active   = locked || s_axis0_tvalid || s_axis1_tvalid;
  assign s_axis0_tready = rst_n && can_load && active && !sel;
  assign s_axis1_tready = rst_n && can_load && active && sel;
  assign in_valid = sel ? s_axis1_tvalid : s_axis0_tvalid;
  assign in_last  = sel ? s_axis1_tlast : s_axis0_tlast;
  assign accept   = in_valid && (sel ? s_axis1_tready : s_axis0_tready);
  assign arb      = accept && !locked;
  assign state_d  = accept ? (in_last ? IDLE : (sel ? LOCK1 : LOCK0)) : (locked ? state_q : IDLE);
  assign last_grant_d = (accept && in_last) ? sel : last_grant_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (accept) begin
        tdata_q  <= sel ? s_axis1_tdata : s_axis0_tdata;
        tkeep_q  <= sel ? s_axis1_tkeep : s_axis0_tkeep;
        tlast_q  <= in_last;
        tuser_q  <= sel;
        tvalid_q <= 1'b1;
      end else if (can_load) begin
        tvalid_q <= 1'b0;
      end
    end
  end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
endmodule

// File: tb/tb_packet_merger.sv
// tb_packet_merger: randomized and directed scoreboard bench for packet_merger.
// With PACKET_MERGER_STARVE_GUARD_EN the DUT is built with STARVE_LIMIT=2.
module tb_packet_merger;
`ifdef PACKET_MERGER_STARVE_GUARD_EN
  localparam int SL = 2;
`else
  localparam int SL = 8;
`endif
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  logic clk = 0, rst_n = 1;
  logic [31:0] s0_data, s1_data, m_data;
  logic [3:0] s0_keep, s1_keep, m_keep;
  logic s0_valid, s1_valid, s0_last, s1_last, s0_ready, s1_ready;
  logic m_valid, m_last, m_user, m_ready;
  logic [1:0] mode;
  packet_merger #(.DATA_WIDTH(32), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis0_tdata(s0_data), .s_axis0_tvalid(s0_valid), .s_axis0_tlast(s0_last),
    .s_axis0_tkeep(s0_keep), .s_axis0_tready(s0_ready),
    .s_axis1_tdata(s1_data), .s_axis1_tvalid(s1_valid), .s_axis1_tlast(s1_last),
    .s_axis1_tkeep(s1_keep), .s_axis1_tready(s1_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tkeep(m_keep), .m_axis_tuser(m_user), .m_axis_tready(m_ready),
    .merge_mode(mode));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  logic exp_src[$];
  logic vld[2], mid[2];
  int acc[2];
  int vpct = 100, rpct = 100, p1_after = 0, stall_left = 0, gaps = 0;
  logic stall_arm = 0, prio_chk = 0, cont_chk = 0, seen_v = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask
  task automatic add_pkt(input int p, input int n, input logic [31:0] base, input logic rnd);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = rnd ? $urandom : base + i;
      b.k = rnd ? 4'($urandom) : 4'hF;
      b.l = (i == n - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask
  task automatic drive();
    beat_t b0, b1;
    b0 = vld[0] ? src_q[0][0] : '0;
    b1 = vld[1] ? src_q[1][0] : '0;
    s0_valid = vld[0]; s0_data = b0.d; s0_keep = b0.k; s0_last = b0.l;
    s1_valid = vld[1]; s1_data = b1.d; s1_keep = b1.k; s1_last = b1.l;
  endtask
  task automatic flush();
    for (int p = 0; p < 2; p++) begin
      src_q[p].delete(); exp_q[p].delete(); vld[p] = 0; mid[p] = 0; acc[p] = 0;
    end
    exp_src.delete();
    drive();
  endtask
  function automatic logic done();
    return src_q[0].size() == 0 && src_q[1].size() == 0 && !vld[0] && !vld[1] &&
           exp_q[0].size() == 0 && exp_q[1].size() == 0;
  endfunction
  task automatic step();
    @(negedge clk);
    if (stall_arm && acc[0] == 2) begin stall_left = 3; stall_arm = 0; end
    for (int p = 0; p < 2; p++)
      if (!vld[p] && src_q[p].size() > 0 && (p == 0 || acc[0] >= p1_after) &&
          $urandom_range(99) < vpct) vld[p] = 1;
    drive();
    m_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
    if (stall_left > 0) stall_left--;
    #1;
    chk("one_tready", {63'd0, s0_ready & s1_ready}, 0);
    if (mid[0]) chk("lock0_blocks_path1", {63'd0, s1_ready}, 0);
    if (mid[1]) chk("lock1_blocks_path0", {63'd0, s0_ready}, 0);
`ifndef PACKET_MERGER_STARVE_GUARD_EN
    if (prio_chk && src_q[1].size() > 0) chk("prio1_path0_ready", {63'd0, s0_ready}, 0);
`endif
    if (cont_chk) begin
      if (m_valid) seen_v = 1;
      else if (seen_v && exp_q[0].size() + exp_q[1].size() > 0) gaps++;
    end
    for (int p = 0; p < 2; p++)
      if (vld[p] && (p == 0 ? s0_ready : s1_ready)) begin
        mid[p] = !src_q[p][0].l;
        void'(src_q[p].pop_front());
        vld[p] = 0;
        acc[p]++;
      end
  endtask
  task automatic run(input int budget);
    int n;
    for (n = 0; n < budget && !done(); n++) step();
    chk("drained", {63'd0, done()}, 1);
    chk("order_consumed", 64'(exp_src.size()), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    beat_t b, e;
    logic in_pkt = 0, cur = 0, ps = 0;
    logic [37:0] pw = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        in_pkt = 0; ps = 0;
      end else begin
        if (ps) begin
          chk("stall_valid", {63'd0, m_valid}, 1);
          chk("stall_hold", {26'd0, m_user, m_last, m_keep, m_data}, {26'd0, pw});
        end
        if (m_valid && m_ready) begin
          b.d = m_data; b.k = m_keep; b.l = m_last;
          if (exp_q[m_user].size() == 0) chk("unexpected_beat", {63'd0, m_user}, 64'h2);
          else begin
            e = exp_q[m_user].pop_front();
            chk(m_user ? "beat_path1" : "beat_path0", {27'd0, b}, {27'd0, e});
          end
          if (!in_pkt) begin
            cur = m_user; in_pkt = 1;
            if (exp_src.size() > 0) chk("pkt_source", {63'd0, m_user}, {63'd0, exp_src.pop_front()});
          end else chk("atomic_source", {63'd0, m_user}, {63'd0, cur});
          if (m_last) in_pkt = 0;
        end
        ps = m_valid && !m_ready;
        pw = {m_user, m_last, m_keep, m_data};
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    logic order[6];
    mode = 2'b00; m_ready = 0;
    flush();
    #2 rst_n = 0;
    #10;
    chk("reset_outputs", {26'd0, m_valid, m_last, m_user, m_keep, m_data}, 0);
    chk("reset_ready", {62'd0, s0_ready, s1_ready}, 0);
    // Round-robin, 3-beat packets, both paths backlogged.
    do_reset();
    mode = 2'b00; vpct = 100; rpct = 100;
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, 3, 32'hA0, 0); add_pkt(1, 3, 32'hB0, 0);
      exp_src.push_back(0); exp_src.push_back(1);
    end
    run(200);
    // Path1 priority with path0 also waiting.
    do_reset();
    mode = 2'b01; prio_chk = 1;
    for (int i = 0; i < 4; i++) add_pkt(1, 2, 32'hC0 + 32'(i * 16), 0);
    for (int i = 0; i < 2; i++) add_pkt(0, 2, 32'hD0 + 32'(i * 16), 0);
`ifdef PACKET_MERGER_STARVE_GUARD_EN
    order = '{1, 1, 0, 1, 1, 0};
`else
    order = '{1, 1, 1, 1, 0, 0};
`endif
    for (int i = 0; i < 6; i++) exp_src.push_back(order[i]);
    run(200);
    prio_chk = 0;
    // Path1 shows up mid-packet on path0, output stalled 3 cycles on beat 2.
    do_reset();
    mode = 2'b00;
    add_pkt(0, 4, 32'h10, 0); add_pkt(1, 1, 32'h20, 0);
    exp_src.push_back(0); exp_src.push_back(1);
    p1_after = 2; stall_arm = 1;
    run(200);
    chk("stall_done", {63'd0, stall_arm}, 0);
    p1_after = 0; stall_arm = 0;
    // Single-beat packets alternate with no output bubbles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 1, 32'h30 + 32'(i), 0); add_pkt(1, 1, 32'h40 + 32'(i), 0);
      exp_src.push_back(0); exp_src.push_back(1);
    end
    cont_chk = 1; seen_v = 0; gaps = 0;
    run(100);
    chk("no_bubble", 64'(gaps), 0);
    cont_chk = 0;
    // Reset while locked on path1, then the first tie must go to path0.
    do_reset();
    add_pkt(1, 4, 32'h50, 0);
    for (int i = 0; i < 50 && acc[1] < 2; i++) step();
    chk("reached_lock1", 64'(acc[1]), 2);
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", {26'd0, m_valid, m_last, m_user, m_keep, m_data}, 0);
    chk("async_reset_ready", {62'd0, s0_ready, s1_ready}, 0);
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1;
    add_pkt(0, 1, 32'h60, 0); add_pkt(1, 1, 32'h70, 0);
    exp_src.push_back(0); exp_src.push_back(1);
    run(100);
    // Random traffic, gaps and backpressure in every mode.
    vpct = 60; rpct = 70;
    for (int r = 0; r < 8; r++) begin
      mode = 2'($urandom);
      for (int i = 0; i < 3; i++) begin
        add_pkt(0, $urandom_range(1, 5), 0, 1);
        add_pkt(1, $urandom_range(1, 5), 0, 1);
      end
      run(2000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
